// File: rtl/cpu_datapath_pkg.sv
// rtl/cpu_datapath_pkg.sv - shared opcode encodings and default widths for the CPU datapath
//
// Purpose : one place for the opcode constants and the default
//           data/address/opcode widths. The controller and the datapath
//           both import this package.
// Ports   : none (package)
// Config  : CPU_DATAPATH_CARRY_EN adds an ADD carry flag in cpu_alu and cpu_datapath
package cpu_datapath_pkg;

    localparam int DWIDTH_DEF = 8;
    localparam int AWIDTH_DEF = 5;
    localparam int OPW_DEF    = 3;

    typedef enum logic [2:0] {
        OP_HLT = 3'b000,
        OP_SKZ = 3'b001,
        OP_ADD = 3'b010,
        OP_AND = 3'b011,
        OP_XOR = 3'b100,
        OP_LDA = 3'b101,
        OP_STO = 3'b110,
        OP_JMP = 3'b111
    } opcode_e;

    // Opcodes whose ALU result is simply the current accumulator.
    function automatic logic is_passthrough(input opcode_e op);
        return (op == OP_HLT) || (op == OP_SKZ) || (op == OP_STO) || (op == OP_JMP);
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// rtl/cpu_alu.sv - combinational ALU for the 8-bit RISC CPU datapath
//
// Purpose : computes the accumulator's next value from opcode, AC and
//           the memory read data. No state.
// Ports   : i_opcode  opcode field of the instruction register
//           i_ac      current accumulator
//           i_data    memory read data
//           o_result  ALU result (candidate next AC)
//           o_carry   ADD carry-out, 0 for other opcodes
//                     (present only with CPU_DATAPATH_CARRY_EN)
// Config  : CPU_DATAPATH_CARRY_EN
module cpu_alu
    import cpu_datapath_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int OPW    = OPW_DEF
) (
    input  logic [OPW-1:0]    i_opcode,
    input  logic [DWIDTH-1:0] i_ac,
    input  logic [DWIDTH-1:0] i_data,
`ifdef CPU_DATAPATH_CARRY_EN
    output logic              o_carry,
`endif
    output logic [DWIDTH-1:0] o_result
);

    opcode_e w_op;
    assign w_op = opcode_e'(i_opcode);

`ifdef CPU_DATAPATH_CARRY_EN
    // One extra bit so the ADD carry can be reported.
    logic [DWIDTH:0] w_sum;
    assign w_sum = {1'b0, i_ac} + {1'b0, i_data};
`else
    // Carry is dropped: the sum wraps modulo 2^DWIDTH.
    logic [DWIDTH-1:0] w_sum;
    assign w_sum = i_ac + i_data;
`endif

    always_comb begin
        o_result = i_ac;
`ifdef CPU_DATAPATH_CARRY_EN
        o_carry  = 1'b0;
`endif
        if (!is_passthrough(w_op)) begin
            case (w_op)
                OP_ADD: begin
                    o_result = w_sum[DWIDTH-1:0];
`ifdef CPU_DATAPATH_CARRY_EN
                    o_carry  = w_sum[DWIDTH];
`endif
                end
                OP_AND:  o_result = i_ac & i_data;
                OP_XOR:  o_result = i_ac ^ i_data;
                OP_LDA:  o_result = i_data;
                default: o_result = i_ac;
            endcase
        end
    end

endmodule

// File: rtl/cpu_datapath.sv
// rtl/cpu_datapath.sv - IR, accumulator, program counter and address mux of the 8-bit RISC CPU
//
// Purpose : register/mux stage driven by the sequencer strobes. Feeds the
//           opcode and zero flag back to the controller.
// Ports   : clk       system clock, rising edge
//           rst       synchronous active-high reset
//           ld_ir     load IR from data_in
//           ld_ac     load AC from ALU result
//           ld_pc     load PC from IR address field (wins over inc_pc)
//           inc_pc    increment PC (wraps at 2^AWIDTH)
//           sel       address select: 1 = PC, 0 = IR address field
//           data_e    drive AC onto the data bus
//           data_in   memory read data
//           data_out  write data, always AC
//           data_oe   data bus output enable (= data_e)
//           addr      memory address
//           opcode    IR opcode field
//           zero      AC == 0
//           carry     ADD carry flag (only with CPU_DATAPATH_CARRY_EN)
// Config  : CPU_DATAPATH_CARRY_EN
// AWIDTH must equal DWIDTH-OPW: the IR is exactly opcode + address.
module cpu_datapath
    import cpu_datapath_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int OPW    = OPW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_ir,
    input  logic              ld_ac,
    input  logic              ld_pc,
    input  logic              inc_pc,
    input  logic              sel,
    input  logic              data_e,
    input  logic [DWIDTH-1:0] data_in,
    output logic [DWIDTH-1:0] data_out,
    output logic              data_oe,
    output logic [AWIDTH-1:0] addr,
    output logic [OPW-1:0]    opcode,
`ifdef CPU_DATAPATH_CARRY_EN
    output logic              carry,
`endif
    output logic              zero
);

    logic [DWIDTH-1:0] r_ir;
    logic [DWIDTH-1:0] r_ac;
    logic [AWIDTH-1:0] r_pc;

    logic [AWIDTH-1:0] w_ir_addr;
    logic [DWIDTH-1:0] w_alu_result;

    assign opcode    = r_ir[DWIDTH-1 -: OPW];
    assign w_ir_addr = r_ir[AWIDTH-1:0];

`ifdef CPU_DATAPATH_CARRY_EN
    logic w_alu_carry;
    logic r_carry;
`endif

    cpu_alu #(
        .DWIDTH (DWIDTH),
        .OPW    (OPW)
    ) u_alu (
        .i_opcode (opcode),
        .i_ac     (r_ac),
        .i_data   (data_in),
`ifdef CPU_DATAPATH_CARRY_EN
        .o_carry  (w_alu_carry),
`endif
        .o_result (w_alu_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ir <= '0;
        end else if (ld_ir) begin
            r_ir <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ac <= '0;
        end else if (ld_ac) begin
            r_ac <= w_alu_result;
        end
    end

`ifdef CPU_DATAPATH_CARRY_EN
    // The ALU already forces carry to 0 for non-ADD opcodes, so any
    // ld_ac simply captures it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_carry <= 1'b0;
        end else if (ld_ac) begin
            r_carry <= w_alu_carry;
        end
    end

    assign carry = r_carry;
`endif

    // ld_pc beats inc_pc so the JMP final state (both asserted) lands
    // exactly on the target address.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= '0;
        end else if (ld_pc) begin
            r_pc <= w_ir_addr;
        end else if (inc_pc) begin
            r_pc <= r_pc + AWIDTH'(1);
        end
    end

    assign addr     = sel ? r_pc : w_ir_addr;
    assign data_out = r_ac;
    assign data_oe  = data_e;
    assign zero     = (r_ac == '0);

endmodule

// File: tb/tb_cpu_datapath.sv
// tb/tb_cpu_datapath.sv - scoreboard testbench for cpu_datapath
module tb_cpu_datapath;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ld_ir = 1'b0, ld_ac = 1'b0, ld_pc = 1'b0, inc_pc = 1'b0;
    logic       sel = 1'b1, data_e = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       data_oe;
    logic [4:0] addr;
    logic [2:0] opcode;
    logic       zero;
`ifdef CPU_DATAPATH_CARRY_EN
    logic       carry;
`endif

    always #5 clk = ~clk;

    cpu_datapath dut (
        .clk      (clk),
        .rst      (rst),
        .ld_ir    (ld_ir),
        .ld_ac    (ld_ac),
        .ld_pc    (ld_pc),
        .inc_pc   (inc_pc),
        .sel      (sel),
        .data_e   (data_e),
        .data_in  (data_in),
        .data_out (data_out),
        .data_oe  (data_oe),
        .addr     (addr),
        .opcode   (opcode),
`ifdef CPU_DATAPATH_CARRY_EN
        .carry    (carry),
`endif
        .zero     (zero)
    );

    localparam int S_OPCODE = 0, S_ZERO = 1, S_DOUT = 2, S_ADDR = 3, S_OE = 4, S_CARRY = 5;

    typedef struct {
        int         sig;
        logic [7:0] val;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    logic chk = 1'b0;

    function automatic logic [7:0] observe(input int sig);
        case (sig)
            S_OPCODE: return {5'b0, opcode};
            S_ZERO:   return {7'b0, zero};
            S_DOUT:   return data_out;
            S_ADDR:   return {3'b0, addr};
            S_OE:     return {7'b0, data_oe};
`ifdef CPU_DATAPATH_CARRY_EN
            S_CARRY:  return {7'b0, carry};
`endif
            default:  return 8'hxx;
        endcase
    endfunction

    // Monitor: drains the scoreboard whenever the stimulus presents a sample point.
    always @(negedge clk) begin
        if (chk) begin
            while (q.size() > 0) begin
                exp_t e;
                logic [7:0] act;
                e = q.pop_front();
                act = observe(e.sig);
                checks = checks + 1;
                if (act !== e.val) begin
                    errors = errors + 1;
                    $display("FAIL %s: got %0h expected %0h", e.nm, act, e.val);
                end
            end
        end
    end

    task automatic expect_v(input int sig, input logic [7:0] val, input string nm);
        exp_t e;
        e.sig = sig;
        e.val = val;
        e.nm  = nm;
        q.push_back(e);
    endtask

    task automatic sample();
        chk = 1'b1;
        @(negedge clk);
        #1;
        chk = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ld_ir = 1'b0; ld_ac = 1'b0; ld_pc = 1'b0; inc_pc = 1'b0; rst = 1'b0;
    endtask

    task automatic load_ir(input logic [7:0] v);
        data_in = v; ld_ir = 1'b1; tick();
    endtask

    task automatic load_ac(input logic [7:0] v);
        data_in = v; ld_ac = 1'b1; tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held two cycles against every strobe.
        rst = 1'b1; ld_ir = 1'b1; ld_ac = 1'b1; ld_pc = 1'b1; inc_pc = 1'b1;
        data_in = 8'hFF; sel = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; ld_ir = 1'b0; ld_ac = 1'b0; ld_pc = 1'b0; inc_pc = 1'b0;
        expect_v(S_OPCODE, 8'h00, "rst_opcode");
        expect_v(S_ZERO,   8'h01, "rst_zero");
        expect_v(S_DOUT,   8'h00, "rst_ac");
        expect_v(S_ADDR,   8'h00, "rst_addr_pc");
`ifdef CPU_DATAPATH_CARRY_EN
        expect_v(S_CARRY,  8'h00, "rst_carry");
`endif
        sample();
        sel = 1'b0;
        expect_v(S_ADDR, 8'h00, "rst_addr_ir");
        sample();

        // LDA 3 with data 05
        load_ir(8'hA3);
        load_ac(8'h05);
        expect_v(S_OPCODE, 8'h05, "lda_opcode");
        expect_v(S_DOUT,   8'h05, "lda_ac");
        expect_v(S_ZERO,   8'h00, "lda_zero");
        expect_v(S_ADDR,   8'h03, "lda_iraddr");
        sample();

        // ADD FC: 05 + FC = 101 -> 01
        load_ir(8'h43);
        load_ac(8'hFC);
        expect_v(S_DOUT, 8'h01, "add_wrap_ac");
`ifdef CPU_DATAPATH_CARRY_EN
        expect_v(S_CARRY, 8'h01, "add_wrap_carry");
`endif
        sample();

        // XOR 01 -> 00
        load_ir(8'h83);
        load_ac(8'h01);
        expect_v(S_DOUT, 8'h00, "xor_ac");
        expect_v(S_ZERO, 8'h01, "xor_zero");
        sample();

        // AND: LDA F0 then AND 3C -> 30
        load_ir(8'hA0);
        load_ac(8'hF0);
        load_ir(8'h60);
        load_ac(8'h3C);
        expect_v(S_DOUT, 8'h30, "and_ac");
        sample();

        // F0 + 20 = 110 -> 10, carry 1; then LDA clears carry
        load_ir(8'hA0);
        load_ac(8'hF0);
        load_ir(8'h40);
        load_ac(8'h20);
        expect_v(S_DOUT, 8'h10, "add_f0_20");
`ifdef CPU_DATAPATH_CARRY_EN
        expect_v(S_CARRY, 8'h01, "carry_set");
`endif
        sample();
        load_ir(8'hA0);
        load_ac(8'h07);
        expect_v(S_DOUT, 8'h07, "lda_after_add");
`ifdef CPU_DATAPATH_CARRY_EN
        expect_v(S_CARRY, 8'h00, "carry_clear");
`endif
        sample();

        // STO is a pass-through: ld_ac keeps AC
        load_ir(8'hC0);
        load_ac(8'hAA);
        expect_v(S_DOUT, 8'h07, "sto_passthru");
        sample();

        // PC wraps 31 -> 0
        do_reset();
        sel = 1'b1;
        for (int i = 0; i < 31; i++) begin
            inc_pc = 1'b1; tick();
        end
        expect_v(S_ADDR, 8'd31, "pc_31");
        sample();
        inc_pc = 1'b1; tick();
        expect_v(S_ADDR, 8'd0, "pc_wrap0");
        sample();
        inc_pc = 1'b1; tick();
        expect_v(S_ADDR, 8'd1, "pc_33inc");
        sample();

        // JMP 29 with ld_pc and inc_pc together
        load_ir(8'hFD);
        ld_pc = 1'b1; inc_pc = 1'b1; tick();
        expect_v(S_OPCODE, 8'h07, "jmp_opcode");
        expect_v(S_ADDR,   8'd29, "jmp_pc");
        sample();

        // Address mux and bus enable: PC=7, IR addr=12, AC=3C
        do_reset();
        for (int i = 0; i < 7; i++) begin
            inc_pc = 1'b1; tick();
        end
        load_ir(8'hA0);
        load_ac(8'h3C);
        load_ir(8'hCC);
        sel = 1'b1;
        expect_v(S_ADDR, 8'd7, "mux_pc");
        sample();
        sel = 1'b0;
        expect_v(S_ADDR, 8'd12, "mux_ir");
        sample();
        data_e = 1'b1;
        expect_v(S_OE,   8'h01, "oe_on");
        expect_v(S_DOUT, 8'h3C, "sto_data");
        sample();
        data_e = 1'b0;
        expect_v(S_OE, 8'h00, "oe_off");
        sample();

        // Reset mid-op beats a concurrent ld_ac
        do_reset();
        sel = 1'b1;
        for (int i = 0; i < 9; i++) begin
            inc_pc = 1'b1; tick();
        end
        load_ir(8'hA0);
        load_ac(8'h55);
        expect_v(S_DOUT, 8'h55, "pre_rst_ac");
        expect_v(S_ADDR, 8'd9,  "pre_rst_pc");
        sample();
        rst = 1'b1; ld_ac = 1'b1; inc_pc = 1'b1; data_in = 8'h77; tick();
        expect_v(S_DOUT,   8'h00, "midrst_ac");
        expect_v(S_ADDR,   8'h00, "midrst_pc");
        expect_v(S_OPCODE, 8'h00, "midrst_opcode");
        expect_v(S_ZERO,   8'h01, "midrst_zero");
        sample();

        if (q.size() != 0) begin
            errors = errors + q.size();
            checks = checks + q.size();
            $display("FAIL scoreboard_drain: %0d left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
